apb_cmd_master: RTL and testbench

Command-driven APB requester that sits directly upstream of the APB register slave and drives its `psel`/`penable`/`pwrite`/`paddr`/`pwdata` bus. Testbench or CPU-side logic pushes read/write commands into a small FIFO through a valid/ready port. The block runs each command as a standard APB SETUP/ACCESS transfer, waits for `pready`, and returns one response per command through a valid/ready response port.

---
 rtl/apb_cmd_master.sv | 157 +++++++++++++++
 tb/tb_apb_cmd_master.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// Command-driven APB requester: FIFO-fed read/write commands run as SETUP/ACCESS transfers,
// one valid/ready response per command. Define APB_CMD_MASTER_TIMEOUT_EN for an ACCESS timeout.
module apb_cmd_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned RDATA_LAG      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W = 1 + ADDR_W + DATA_W;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RDATA_LAG > 1 ||
      TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_cmd_master: illegal parameter value");
  end

  typedef enum logic [2:0] {StIdle, StSetup, StAccess, StCapture, StResp} state_e;

  state_e           state_q;
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic             fifo_empty, fifo_full, push, pop;
  logic [ENT_W-1:0] head;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign pop        = (state_q == StIdle) && !fifo_empty;
  assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];
  assign busy       = !fifo_empty || (state_q != StIdle);

  always_ff @(posedge pclk) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned        CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= StIdle;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            {pwrite, paddr, pwdata} <= head;
            psel    <= 1'b1;
            state_q <= StSetup;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
          end
        end
        StSetup: begin
          penable <= 1'b1;
          state_q <= StAccess;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        StAccess: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (RDATA_LAG == 0) begin
              rsp_rdata <= pwrite ? '0 : prdata;
              rsp_valid <= 1'b1;
              state_q   <= StResp;
            end else begin
              state_q   <= StCapture;
            end
          end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            // Abandon the stalled transfer and report it as an error response.
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_rdata <= '0;
            err_q     <= 1'b1;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        StCapture: begin
          // Slave's prdata is registered one cycle after the completing ACCESS edge.
          rsp_rdata <= pwrite ? '0 : prdata;
          rsp_valid <= 1'b1;
          state_q   <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Randomized self-checking bench for apb_cmd_master: behavioural APB slave, queue-based
// response model and APB protocol monitor. Covers APB_CMD_MASTER_TIMEOUT_EN when defined.
module tb_apb_cmd_master;

  localparam int unsigned RDATA_LAG      = 1;
  localparam int unsigned TIMEOUT_CYCLES = 16;

  typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} apb_t;
  typedef struct packed {logic [31:0] rdata; logic err;} rsp_t;

  logic        pclk, preset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite, pready;
  logic [31:0] paddr, pwdata, prdata;

  logic [7:0]  wait_n;
  logic [7:0]  acc_cycles;
  logic [1:0]  rsp_mode;      // 0: ready high, 1: ready low, 2: random
  logic [31:0] slv_mem [16];
  logic [31:0] ref_mem [16];
  apb_t        apb_q [$];
  rsp_t        exp_q [$];
  apb_t        cur;
  logic        prev_psel;

  int n_checks = 0;
  int n_pass   = 0;

  apb_cmd_master #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .FIFO_DEPTH    (4),
    .RDATA_LAG     (RDATA_LAG),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Slave: 16 words at 0xA000, registered prdata, unmapped reads return 0.
  assign pready = (acc_cycles >= wait_n);

  always @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      prdata     <= '0;
      acc_cycles <= '0;
      for (int i = 0; i < 16; i++) slv_mem[i] <= '0;
    end else begin
      acc_cycles <= (psel && penable && !pready) ? acc_cycles + 8'd1 : 8'd0;
      if (psel && penable && pready) begin
        if (pwrite) begin
          if ((paddr & 32'hFFFF_FFC0) == 32'h0000_A000) slv_mem[paddr[5:2]] <= pwdata;
        end else begin
          prdata <= ((paddr & 32'hFFFF_FFC0) == 32'h0000_A000) ? slv_mem[paddr[5:2]] : 32'h0;
        end
      end
    end
  end

  // Expected response and APB transfer are known as soon as a command is accepted.
  task automatic model_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic tmo);
    rsp_t r;
    apb_t t;
    logic hit;
    hit     = ((a & 32'hFFFF_FFC0) == 32'h0000_A000);
    t.w     = w;
    t.a     = a;
    t.d     = d;
    apb_q.push_back(t);
    r.err   = tmo;
    r.rdata = 32'h0;
    if (!tmo && hit) begin
      if (w) ref_mem[a[5:2]] = d;
      else   r.rdata = ref_mem[a[5:2]];
    end
    exp_q.push_back(r);
  endtask

  // Response monitor
  always @(negedge pclk) begin
    if (preset_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1'b1, 1'b0);
      end else begin
        check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        check("rsp_err", rsp_err, exp_q[0].err);
        void'(exp_q.pop_front());
      end
    end
  end

  // APB monitor: SETUP only after idle, ACCESS only after SETUP/ACCESS, fields match command.
  always @(negedge pclk) begin
    if (preset_n) begin
      if (psel && !penable) begin
        check("setup_after_idle", prev_psel, 1'b0);
        if (apb_q.size() == 0) check("apb_unexpected", 1'b1, 1'b0);
        else cur <= apb_q.pop_front();
      end
      if (psel && penable) begin
        check("access_after_setup", prev_psel, 1'b1);
        check("access_paddr", paddr, cur.a);
        check("access_pwrite", pwrite, cur.w);
        if (cur.w) check("access_pwdata", pwdata, cur.d);
      end
      if (penable && !psel) check("penable_without_psel", penable, 1'b0);
    end
    prev_psel <= psel;
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge pclk);
      #1;
      if (rsp_mode == 2'd2) rsp_ready = ($urandom_range(0, 2) != 0);
      else                  rsp_ready = (rsp_mode == 2'd0);
    end
  end

  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic tmo);
    int guard;
    guard     = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge pclk);
    while (!cmd_ready && guard < 200) begin
      guard++;
      @(negedge pclk);
    end
    check("cmd_accepted", cmd_ready, 1'b1);
    model_cmd(w, a, d, tmo);
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Single command into an idle block; response must appear 3 + RDATA_LAG + waits edges later.
  task automatic timed_cmd(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] d);
    int n;
    int exp_lat;
    exp_lat = 3 + int'(RDATA_LAG) + int'(wait_n);
    push_cmd(w, a, d, 1'b0);
    n = 0;
    @(negedge pclk);
    while (!rsp_valid && n < 100) begin
      n++;
      @(negedge pclk);
    end
    check(tag, n, exp_lat);
    @(posedge pclk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n        = 0;
    rsp_mode = 2'd0;
    @(negedge pclk);
    while ((busy || rsp_valid || exp_q.size() != 0) && n < 1000) begin
      n++;
      @(negedge pclk);
    end
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_pending"}, exp_q.size(), 0);
    @(posedge pclk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_psel"}, psel, 1'b0);
    check({tag, "_penable"}, penable, 1'b0);
    check({tag, "_pwrite"}, pwrite, 1'b0);
    check({tag, "_paddr"}, paddr, 32'h0);
    check({tag, "_pwdata"}, pwdata, 32'h0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_psel;
    int n_rsp;
    int guard;
    logic        w;
    logic [31:0] a;
    preset_n  = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    wait_n    = 8'd0;
    rsp_mode  = 2'd0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check_reset_outputs("reset");
    preset_n = 1'b1;
    @(posedge pclk);
    #1;

    // Directed: write/read, unmapped read, wait states
    timed_cmd("lat_write", 1'b1, 32'h0000_A000, 32'hDEAD_BEEF);
    timed_cmd("lat_read", 1'b0, 32'h0000_A000, 32'h0);
    timed_cmd("lat_unmapped", 1'b0, 32'h0000_B000, 32'h0);
    wait_n = 8'd3;
    timed_cmd("lat_read_wait3", 1'b0, 32'h0000_A000, 32'h0);
    timed_cmd("lat_write_wait3", 1'b1, 32'h0000_A004, 32'h0BAD_F00D);
    wait_n = 8'd0;
    drain("directed");

    // Back-pressure: RESP stalled, FIFO fills behind it
    rsp_mode = 2'd1;
    repeat (2) begin
      @(posedge pclk);
      #1;
    end
    push_cmd(1'b0, 32'h0000_A000, 32'h0, 1'b0);
    push_cmd(1'b1, 32'h0000_A008, 32'h1111_2222, 1'b0);
    push_cmd(1'b0, 32'h0000_A008, 32'h0, 1'b0);
    push_cmd(1'b0, 32'h0000_A004, 32'h0, 1'b0);
    push_cmd(1'b1, 32'h0000_A00C, 32'h3333_4444, 1'b0);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_A00C;
    @(negedge pclk);
    check("bp_rsp_valid", rsp_valid, 1'b1);
    check("bp_busy", busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("bp_cmd_ready_low", cmd_ready, 1'b0);
      @(posedge pclk);
      #1;
      @(negedge pclk);
    end
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
    drain("backpressure");
    check("bp_cmd_ready_high", cmd_ready, 1'b1);

    // Randomized traffic with random wait states and response back-pressure
    rsp_mode = 2'd2;
    for (int i = 0; i < 80; i++) begin
      wait_n = 8'($urandom_range(0, 2));
      w      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) a = 32'h0000_B000 + (32'($urandom_range(0, 3)) << 2);
      else                           a = 32'h0000_A000 + (32'($urandom_range(0, 15)) << 2);
      push_cmd(w, a, $urandom, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) begin
          @(posedge pclk);
          #1;
        end
      end
    end
    wait_n = 8'd0;
    drain("random");

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    // Stuck slave: ACCESS abandoned after TIMEOUT_CYCLES, next command runs normally
    wait_n = 8'hFF;
    push_cmd(1'b0, 32'h0000_A000, 32'h0, 1'b1);
    push_cmd(1'b1, 32'h0000_A008, 32'h0000_1234, 1'b0);
    n_psel = 0;
    guard  = 0;
    @(negedge pclk);
    while (!rsp_valid && guard < 200) begin
      if (penable) n_psel++;
      guard++;
      @(negedge pclk);
    end
    wait_n = 8'd0;
    check("timeout_access_cycles", n_psel, TIMEOUT_CYCLES);
    drain("timeout");
    push_cmd(1'b0, 32'h0000_A008, 32'h0, 1'b0);
    drain("after_timeout");
`endif

    // Reset during ACCESS with commands queued: everything flushed, nothing emitted
    wait_n = 8'd5;
    push_cmd(1'b0, 32'h0000_A000, 32'h0, 1'b0);
    push_cmd(1'b0, 32'h0000_A004, 32'h0, 1'b0);
    push_cmd(1'b0, 32'h0000_A008, 32'h0, 1'b0);
    guard = 0;
    @(negedge pclk);
    while (!penable && guard < 50) begin
      guard++;
      @(negedge pclk);
    end
    check("rst_reached_access", penable, 1'b1);
    #1;
    preset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    exp_q.delete();
    apb_q.delete();
    wait_n = 8'd0;
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    n_psel = 0;
    n_rsp  = 0;
    repeat (20) begin
      @(negedge pclk);
      if (psel) n_psel++;
      if (rsp_valid) n_rsp++;
    end
    check("rst_no_apb", n_psel, 0);
    check("rst_no_rsp", n_rsp, 0);
    check("rst_idle_busy", busy, 1'b0);
    check("rst_idle_cmd_ready", cmd_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
